cpu_core: RTL
=============

CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 16, data/instruction word width (legal 16..32).
REQ-002 SHALL provide parameter REG_COUNT, default 8, number of general registers (power of two, 4..16); REG_ADDR_SIZE = clog2(REG_COUNT).
REQ-003 SHALL provide parameter MEM_ADDR_SIZE, default 16, memory address width.
REQ-004 clock  input  1  rising-edge clock; the block uses one clock.
REQ-005 reset  input  1  reset is asynchronous and active-low.
REQ-006 execute  input  1  level; starts or continues execution from IDLE.
REQ-007 mem_ready  input  1  memory completes current read/write this cycle.
REQ-008 mem_read_data  input  WORD_SIZE  read data, valid when mem_ready=1.
REQ-009 mem_address  output  MEM_ADDR_SIZE  registered transaction address.
REQ-010 mem_write_data  output  WORD_SIZE  registered store data.
REQ-011 mem_read / mem_write  output  1 each  request strobes, never both high.
REQ-012 halted  output  1  high in HALTED state.
REQ-013 state  output  4  current FSM state (debug).
REQ-014 opcode  output  4  opcode of the current instruction (debug).

Function
REQ-015 Instruction fields: opcode = top 4 bits; reg1, reg2 = next two REG_ADDR_SIZE fields; big_immediate = low 8 bits; small_immediate = low 4 bits; opcode encodings come from the shared parameter header.
REQ-016 FSM states: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, NEXT, HALTED.
REQ-017 Transitions: IDLE->FETCH on execute=1; FETCH->DECODE on mem_ready; DECODE->EXECUTE; EXECUTE->MEMORY (LOAD/STORE), ->HALTED (HALT), ->NEXT (branches), else ->WRITEBACK; MEMORY->WRITEBACK (LOAD) or ->NEXT (STORE) on mem_ready; WRITEBACK->NEXT; NEXT->FETCH if execute=1, else ->IDLE.
REQ-018 A memory request SHALL hold address, data and strobe stable until the cycle mem_ready=1 samples high; waits are unbounded.
REQ-019 mem_ready while no request is outstanding SHALL be ignored.
REQ-020 ALU ops (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR) SHALL compute modulo 2^WORD_SIZE, with result into reg1.
REQ-021 ADDI/ANDI use big_immediate zero-extended; LUI writes big_immediate<<(WORD_SIZE-8); LI replaces the low 8 bits of reg1 and keeps the rest; MV copies reg2 to reg1.
REQ-022 LOAD address = reg2[MEM_ADDR_SIZE-1:0]; STORE address = reg2 + zero-extended small_immediate, truncated; STORE data = reg1.
REQ-023 BEQ taken iff reg1 == reg2 (full width); BNE taken iff different; a taken branch loads the PC with zero-extended big_immediate.
REQ-024 Untaken/non-branch: PC <= PC+1, wrapping from 2^MEM_ADDR_SIZE-1 to 0.
REQ-025 Register writes occur only in WRITEBACK; writes to a register and a read of it in the same instruction see the old value.
REQ-026 HALTED is sticky; only reset leaves it; execute is ignored there.
REQ-027 Undefined opcodes SHALL execute as NOP (PC+1).

Reset
REQ-028 While reset=0: state=IDLE, PC=0, all registers=0, mem_read=mem_write=0, mem_address=0, mem_write_data=0, halted=0, opcode=0.
REQ-029 Reset asserted mid-transaction SHALL drop the strobes immediately (asynchronously); the transaction is abandoned.
REQ-030 After release, the first state change occurs on the first rising edge with execute=1.

Configuration
REQ-031 Macro CPU_CORE_CYCLE_COUNT_EN: when defined, adds output cycle_count (32 bit), cleared by reset, incremented every clock while state is not IDLE or HALTED, saturating at all-ones.
REQ-032 When CPU_CORE_CYCLE_COUNT_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Program LI r1,5; LI r2,7; ADD r1,r2; HALT with mem_ready always 1 -> r1=12, halted=1, PC=3.
REQ-034 LOAD with mem_ready delayed 3 cycles -> mem_read and mem_address held 4 cycles, register written once.
REQ-035 WORD_SIZE=32: LUI r3,0xAB -> r3=0xAB000000; ADD 0xFFFFFFFF+1 -> 0.
REQ-036 BEQ r1,r2 with r1=r2=0x0102 -> PC=target; with r1=0x0102, r2=0x0103 -> PC+1.
REQ-037 Assert reset during a STORE wait -> mem_write falls the same cycle, state=IDLE, PC=0.
REQ-038 With the macro defined, 4-instruction program with no waits -> cycle_count equals the measured active cycles; it is frozen after HALT.

Source files
------------

// File: rtl/cpu_core.sv
// cpu_core -- small multi-cycle load/store CPU with a single-port memory bus.
//
// Each instruction walks IDLE/NEXT -> FETCH -> DECODE -> EXECUTE ->
// [MEMORY] -> [WRITEBACK] -> NEXT. A memory request (read or write) is
// registered when its state is entered. Its address, data and strobe stay
// stable until mem_ready is sampled high. mem_ready is ignored in all other
// states.
//
// Instruction word: [W-1:W-4] opcode, then reg1, reg2 (REG_ADDR_SIZE each);
// big_immediate = [7:0], small_immediate = [3:0] (fields may overlap).
// Opcode map:
//   0 ADD  1 SUB  2 AND  3 OR  4 XOR
//   5 UNARY (imm4[1:0]: 0 NOT reg1=~reg2, 1 MV reg1=reg2, else NOP)
//   6 SHIFT (imm4[1:0]: 0 SHL reg1<<=reg2, 1 SHR reg1>>=reg2, else NOP)
//   7 ADDI 8 ANDI 9 LUI A LI B LOAD C STORE D BEQ E BNE F HALT
// Assumes 8 <= MEM_ADDR_SIZE <= WORD_SIZE.
//
// Ports:
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_execute                 run enable (sampled in IDLE and NEXT)
//   i_mem_ready               current memory request completes this cycle
//   i_mem_read_data           read data, valid with i_mem_ready
//   o_mem_address             registered request address
//   o_mem_write_data          registered store data
//   o_mem_read / o_mem_write  request strobes
//   o_halted                  high in HALTED
//   o_state / o_opcode        debug: FSM state, current opcode
//   o_cycle_count             only with CPU_CORE_CYCLE_COUNT_EN defined:
//                             saturating count of non-IDLE, non-HALTED clocks
module cpu_core #(
   parameter int WORD_SIZE     = 16,
   parameter int REG_COUNT     = 8,
   parameter int MEM_ADDR_SIZE = 16
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_execute,
   input  logic                     i_mem_ready,
   input  logic [WORD_SIZE-1:0]     i_mem_read_data,
   output logic [MEM_ADDR_SIZE-1:0] o_mem_address,
   output logic [WORD_SIZE-1:0]     o_mem_write_data,
   output logic                     o_mem_read,
   output logic                     o_mem_write,
   output logic                     o_halted,
   output logic [3:0]               o_state,
   output logic [3:0]               o_opcode
`ifdef CPU_CORE_CYCLE_COUNT_EN
   ,
   output logic [31:0]              o_cycle_count
`endif
);
   localparam int W  = WORD_SIZE;
   localparam int M  = MEM_ADDR_SIZE;
   localparam int RA = $clog2(REG_COUNT);

   localparam logic [3:0] OP_ADD   = 4'h0, OP_SUB   = 4'h1, OP_AND  = 4'h2,
                          OP_OR    = 4'h3, OP_XOR   = 4'h4, OP_UNARY = 4'h5,
                          OP_SHIFT = 4'h6, OP_ADDI  = 4'h7, OP_ANDI = 4'h8,
                          OP_LUI   = 4'h9, OP_LI    = 4'hA, OP_LOAD = 4'hB,
                          OP_STORE = 4'hC, OP_BEQ   = 4'hD, OP_BNE  = 4'hE,
                          OP_HALT  = 4'hF;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXECUTE = 4'd3,
      S_MEMORY = 4'd4, S_WRITEBACK = 4'd5, S_NEXT = 4'd6, S_HALTED = 4'd7
   } state_t;

   state_t                      r_state, w_next;
   logic [M-1:0]                r_pc;
   logic [W-1:0]                r_ir;
   logic [REG_COUNT-1:0][W-1:0] r_regs;
   logic [W-1:0]                r_result;
   logic                        r_wen, r_take;
   logic                        r_mem_read, r_mem_write;
   logic [M-1:0]                r_mem_address;
   logic [W-1:0]                r_mem_write_data;

   logic [3:0]    w_op;
   logic [RA-1:0] w_r1, w_r2;
   logic [7:0]    w_imm8;
   logic [3:0]    w_imm4;
   logic [W-1:0]  w_a, w_b, w_zimm8, w_st_sum, w_result;
   logic          w_wen, w_take;
   logic [M-1:0]  w_pc_next;

   assign w_op     = r_ir[W-1 -: 4];
   assign w_r1     = r_ir[W-5 -: RA];
   assign w_r2     = r_ir[W-5-RA -: RA];
   assign w_imm8   = r_ir[7:0];
   assign w_imm4   = r_ir[3:0];
   assign w_a      = r_regs[w_r1];
   assign w_b      = r_regs[w_r2];
   assign w_zimm8  = {{(W-8){1'b0}}, w_imm8};
   assign w_st_sum = w_b + {{(W-4){1'b0}}, w_imm4};
   assign w_take   = ((w_op == OP_BEQ) && (w_a == w_b)) ||
                     ((w_op == OP_BNE) && (w_a != w_b));
   // r_take/r_ir are stable from EXECUTE through NEXT
   assign w_pc_next = r_take ? {{(M-8){1'b0}}, w_imm8} : r_pc + 1'b1;

   // Register-file result; w_wen=0 turns the instruction into a NOP.
   always_comb begin
      w_result = w_a;
      w_wen    = 1'b1;
      case (w_op)
         OP_ADD:   w_result = w_a + w_b;
         OP_SUB:   w_result = w_a - w_b;
         OP_AND:   w_result = w_a & w_b;
         OP_OR:    w_result = w_a | w_b;
         OP_XOR:   w_result = w_a ^ w_b;
         OP_UNARY: case (w_imm4[1:0])
                      2'd0:    w_result = ~w_b;
                      2'd1:    w_result = w_b;
                      default: w_wen = 1'b0;
                   endcase
         OP_SHIFT: case (w_imm4[1:0])
                      2'd0:    w_result = w_a << w_b;
                      2'd1:    w_result = w_a >> w_b;
                      default: w_wen = 1'b0;
                   endcase
         OP_ADDI:  w_result = w_a + w_zimm8;
         OP_ANDI:  w_result = w_a & w_zimm8;
         OP_LUI:   w_result = {w_imm8, {(W-8){1'b0}}};
         OP_LI:    w_result = {w_a[W-1:8], w_imm8};
         default:  w_wen = 1'b0;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (i_execute) w_next = S_FETCH;
         S_FETCH:     if (i_mem_ready) w_next = S_DECODE;
         S_DECODE:    w_next = S_EXECUTE;
         S_EXECUTE:   case (w_op)
                         OP_LOAD, OP_STORE: w_next = S_MEMORY;
                         OP_HALT:           w_next = S_HALTED;
                         OP_BEQ, OP_BNE:    w_next = S_NEXT;
                         default:           w_next = S_WRITEBACK;
                      endcase
         S_MEMORY:    if (i_mem_ready) w_next = (w_op == OP_LOAD) ? S_WRITEBACK : S_NEXT;
         S_WRITEBACK: w_next = S_NEXT;
         S_NEXT:      w_next = i_execute ? S_FETCH : S_IDLE;
         S_HALTED:    w_next = S_HALTED;
         default:     w_next = S_IDLE;
      endcase
   end

   // Datapath and bus registers. Requests are launched on the edge that
   // enters FETCH/MEMORY so the strobe is registered from its first cycle.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pc             <= '0;
         r_ir             <= '0;
         r_regs           <= '0;
         r_result         <= '0;
         r_wen            <= 1'b0;
         r_take           <= 1'b0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_execute) begin
               r_mem_read    <= 1'b1;
               r_mem_address <= r_pc;
            end
            S_FETCH: if (i_mem_ready) begin
               r_mem_read <= 1'b0;
               r_ir       <= i_mem_read_data;
            end
            S_EXECUTE: begin
               r_result <= w_result;
               r_wen    <= w_wen || (w_op == OP_LOAD);
               r_take   <= w_take;
               if (w_op == OP_LOAD) begin
                  r_mem_read    <= 1'b1;
                  r_mem_address <= w_b[M-1:0];
               end
               if (w_op == OP_STORE) begin
                  r_mem_write      <= 1'b1;
                  r_mem_address    <= w_st_sum[M-1:0];
                  r_mem_write_data <= w_a;
               end
            end
            S_MEMORY: if (i_mem_ready) begin
               if (r_mem_read) r_result <= i_mem_read_data;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
            end
            S_WRITEBACK: if (r_wen) r_regs[w_r1] <= r_result;
            S_NEXT: begin
               r_pc <= w_pc_next;
               if (i_execute) begin
                  r_mem_read    <= 1'b1;
                  r_mem_address <= w_pc_next;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CPU_CORE_CYCLE_COUNT_EN
   logic [31:0] r_cycle_count;
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         r_cycle_count <= '0;
      else if ((r_state != S_IDLE) && (r_state != S_HALTED) && (r_cycle_count != 32'hFFFF_FFFF))
         r_cycle_count <= r_cycle_count + 32'd1;
   end
   assign o_cycle_count = r_cycle_count;
`endif

   assign o_mem_address    = r_mem_address;
   assign o_mem_write_data = r_mem_write_data;
   assign o_mem_read       = r_mem_read;
   assign o_mem_write      = r_mem_write;
   assign o_halted         = (r_state == S_HALTED);
   assign o_state          = r_state;
   assign o_opcode         = w_op;
endmodule
